muldiv_unit: RTL

Iterative multiply/divide unit producing the HI/LO pair for MULT, MULTU, DIV and DIVU. It consumes the two operands read from the register file (rs and rt). HI and LO feed MFHI/MFLO back to the register-file write port. One bit is processed per cycle behind a start/busy/done handshake, so the pipeline stalls on busy instead of carrying a combinational multiplier.

---
 rtl/muldiv_pkg.sv | 13 +
 rtl/muldiv_unit.sv | 139 +++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and the sign-fix helper shared by muldiv_unit.
package muldiv_pkg;
  localparam int MAX_W = 64;
  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;
  typedef logic [2*MAX_W-1:0] wide_t;
  function automatic wide_t neg_if(input wide_t v, input logic n);
    return n ? -v : v;
  endfunction
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative one-bit-per-cycle MULT/MULTU/DIV/DIVU producing HI/LO.
// WIDTH must stay below muldiv_pkg::MAX_W so the sign-fix helper has headroom.
module muldiv_unit import muldiv_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic div_q, div_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d, dz_q, dz_d;
  logic done_q, done_d, dbz_q, dbz_d;
  logic [WIDTH-1:0] opnd_q, opnd_d, a_raw_q, a_raw_d, rem_q, rem_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic sgn_op, div_op, a_neg, b_neg, unused_fix;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0] sum, rem_sh, trial;
  wide_t prod_fix, quo_fix, rem_fix;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    div_d = div_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    dz_d = dz_q;
    opnd_d = opnd_q;
    a_raw_d = a_raw_q;
    rem_d = rem_q;
    acc_d = acc_q;
    hi_d = hi_q;
    lo_d = lo_q;
    done_d = 1'b0;
    dbz_d = 1'b0;
    sgn_op = (op == OP_MULT) || (op == OP_DIV);
    div_op = (op == OP_DIV) || (op == OP_DIVU);
    a_neg = sgn_op && a[WIDTH-1];
    b_neg = sgn_op && b[WIDTH-1];
    mag_a = a_neg ? -a : a;
    mag_b = b_neg ? -b : b;
    sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    rem_sh = {rem_q, acc_q[WIDTH-1]};
    trial = rem_sh - {1'b0, opnd_q};
    prod_fix = neg_if(wide_t'(acc_q), neg_q_q);
    quo_fix = neg_if(wide_t'(acc_q[WIDTH-1:0]), neg_q_q);
    rem_fix = neg_if(wide_t'(rem_q), neg_r_q);
    unused_fix = ^{prod_fix[2*MAX_W-1:2*WIDTH], quo_fix[2*MAX_W-1:WIDTH], rem_fix[2*MAX_W-1:WIDTH]};
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d = CW'(WIDTH);
          div_d = div_op;
          neg_q_d = a_neg ^ b_neg;
          neg_r_d = a_neg;
          dz_d = div_op && (b == '0);
          a_raw_d = a;
          // Multiply adds the multiplicand into an accumulator seeded with the multiplier;
          // divide shifts the dividend out of the accumulator against the divisor.
          opnd_d = div_op ? mag_b : mag_a;
          acc_d = {{WIDTH{1'b0}}, div_op ? mag_a : mag_b};
          rem_d = '0;
        end else begin
          hi_d = hi_we ? wdata : hi_q;
          lo_d = lo_we ? wdata : lo_q;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        state_d = (cnt_d == '0) ? FIX : RUN;
        if (div_q) begin
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~trial[WIDTH]};
          rem_d = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        end else begin
          acc_d = acc_q[0] ? {sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
        end
      end
      FIX: begin
        state_d = IDLE;
        done_d = 1'b1;
        dbz_d = div_q && dz_q;
        hi_d = div_q ? (dz_q ? a_raw_q : rem_fix[WIDTH-1:0]) : prod_fix[2*WIDTH-1:WIDTH];
        lo_d = div_q ? (dz_q ? '1 : quo_fix[WIDTH-1:0]) : prod_fix[WIDTH-1:0];
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      div_q <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      dz_q <= 1'b0;
      opnd_q <= '0;
      a_raw_q <= '0;
      rem_q <= '0;
      acc_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      done_q <= 1'b0;
      dbz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      dz_q <= dz_d;
      opnd_q <= opnd_d;
      a_raw_q <= a_raw_d;
      rem_q <= rem_d;
      acc_q <= acc_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      done_q <= done_d;
      dbz_q <= dbz_d;
    end
  end
  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign div_by_zero = dbz_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule
